// File: rtl/divider.sv
// Iterative restoring divider with RISC-V M semantics (DIV/DIVU/REM/REMU).
// Divide-by-zero and signed overflow finish in one cycle; other operations take WIDTH steps.
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    output logic             ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic             is_rem_q, is_rem_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, overflow, fast;
    logic [WIDTH-1:0] fast_result;

    logic [WIDTH+1:0] rem_shift, diff;
    logic             no_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] r_final;
    logic             last_step;
    logic [WIDTH-1:0] calc_result;

    // Operand decode at the accepting edge
    always_comb begin
        accept      = (state_q == StIdle) && start && !abort;
        a_neg       = !op[0] && operand_a[WIDTH-1];
        b_neg       = !op[0] && operand_b[WIDTH-1];
        a_mag       = a_neg ? -operand_a : operand_a;
        b_mag       = b_neg ? -operand_b : operand_b;
        div_zero    = (operand_b == '0);
        overflow    = !op[0] && (operand_a == MinInt) && (operand_b == '1);
        fast        = div_zero || overflow;
        fast_result = op[1] ? (div_zero ? operand_a : '0) : (div_zero ? '1 : MinInt);
    end

    // One restoring step; the extra top bit of the difference is the borrow
    always_comb begin
        rem_shift   = {rem_q, quot_q[WIDTH-1]};
        diff        = rem_shift - {2'b00, divisor_q};
        no_borrow   = !diff[WIDTH+1];
        rem_next    = no_borrow ? diff[WIDTH:0] : rem_shift[WIDTH:0];
        quot_next   = {quot_q[WIDTH-2:0], no_borrow};
        r_final     = rem_next[WIDTH-1:0];
        last_step   = (count_q == CntW'(WIDTH - 1));
        calc_result = is_rem_q ? (rem_neg_q ? -r_final : r_final)
                               : (quo_neg_q ? -quot_next : quot_next);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = fast ? StDone : StCalc;
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        is_rem_d  = is_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        count_d   = count_q;
        result_d  = result_q;
        if (accept) begin
            is_rem_d  = op[1];
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            quot_d    = a_mag;
            divisor_d = b_mag;
            rem_d     = '0;
            count_d   = '0;
            if (fast) begin
                result_d = fast_result;
            end
        end else if (state_q == StCalc && !abort) begin
            rem_d   = rem_next;
            quot_d  = quot_next;
            count_d = count_q + CntW'(1);
            if (last_step) begin
                result_d = calc_result;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            quot_q    <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
        end else begin
            is_rem_q  <= is_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        ready        = (state_q == StIdle);
        result_valid = (state_q == StDone);
        result       = result_q;
    end

endmodule

// File: tb/tb_divider.sv
// Randomised and directed bench for divider against a plain-arithmetic RISC-V M model.
module tb_divider;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         abort;
    logic         ready;
    logic         result_valid;
    logic [W-1:0] result;

    int           n_vec;
    int           n_mis;
    logic [W-1:0] last_exp;

    divider #(.WIDTH(W)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .abort        (abort),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Issue one operation; optionally keep start high with junk operands while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit junk);
        int           cyc;
        logic [W-1:0] exp;
        exp = model(o, a, b);
        cyc = 0;
        while (!ready && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock); #1;
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < 45) begin
            if (junk) begin
                start     = 1'b1;
                op        = 2'($urandom_range(0, 3));
                operand_a = $urandom;
                operand_b = $urandom;
            end
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_lat"}, 64'(cyc), 64'(model_lat(o, a, b)));
        check_eq({tag, "_res"}, 64'(result), 64'(exp));
        @(posedge clock); #1;
        check_eq({tag, "_idle"}, {63'b0, ready}, 64'd1);
        check_eq({tag, "_hold"}, 64'(result), 64'(exp));
        last_exp = exp;
    endtask

    initial begin
        int  seen;
        int  sel;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        n_vec     = 0;
        n_mis     = 0;
        start     = 1'b0;
        abort     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        reset_n   = 1'b0;
        #1;
        check_eq("rst_ready", {63'b0, ready}, 64'd1);
        check_eq("rst_valid", {63'b0, result_valid}, 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        #13 reset_n = 1'b1;
        @(posedge clock); #1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b1);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1'b0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1'b0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_123_5", 2'b01, 32'd123, 32'd5, 1'b0);

        // Abort ten cycles into CALC
        start     = 1'b1;
        op        = 2'b01;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clock); #1;
        end
        check_eq("abort_busy", {63'b0, ready}, 64'd0);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_eq("abort_ready", {63'b0, ready}, 64'd1);
        check_eq("abort_valid", {63'b0, result_valid}, 64'd0);
        check_eq("abort_result", 64'(result), 64'(last_exp));
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (result_valid) seen++;
        end
        check_eq("abort_no_pulse", 64'(seen), 64'd0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0);

        // Asynchronous reset between edges during CALC
        start     = 1'b1;
        op        = 2'b00;
        operand_a = 32'd77777;
        operand_b = 32'd13;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_ready", {63'b0, ready}, 64'd1);
        check_eq("arst_valid", {63'b0, result_valid}, 64'd0);
        check_eq("arst_result", 64'(result), 64'd0);
        #3 reset_n = 1'b1;
        run_op("post_rst", 2'b01, 32'd200, 32'd9, 1'b0);

        // abort beats start in IDLE (divide by zero would otherwise pulse next cycle)
        start     = 1'b1;
        abort     = 1'b1;
        op        = 2'b01;
        operand_a = 32'd8;
        operand_b = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("idle_abort_ready", {63'b0, ready}, 64'd1);
        check_eq("idle_abort_valid", {63'b0, result_valid}, 64'd0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 7);
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = '0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
